// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the RAM port arbiter.
// Optional error counter is enabled by RAM_PORT_ARBITER_ERR_CNT_EN.
package ram_port_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    localparam int unsigned ERR_CNT_W = 16;

    function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_picker.sv
// Round-robin picker: first requesting index strictly after `last`, wrapping to 0.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        // Upper segment above `last` has priority over the wrapped lower segment.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i > 32'(last))) begin
                any     = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i <= 32'(last))) begin
                any     = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Multi-requester arbiter for a single-port RAM with round-robin and lock ownership.
// Define RAM_PORT_ARBITER_ERR_CNT_EN to add the saturating err_count output.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             lock,
    input  logic [NUM_REQ-1:0]             we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [NUM_REQ-1:0]             err,
    output logic                           ram_en,
    output logic                           ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [DATA_WIDTH-1:0]          ram_wdata,
    input  logic [DATA_WIDTH-1:0]          ram_rdata
`ifdef RAM_PORT_ARBITER_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]           err_count
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t          state;
    logic [IDX_W-1:0]    owner;
    logic [IDX_W-1:0]    last_gnt;

    logic [NUM_REQ-1:0]  rr_gnt;
    logic [IDX_W-1:0]    rr_idx;
    logic                rr_any;

    logic                hold;
    logic                sel_any;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                oor;
    logic [NUM_REQ-1:0]  gnt_int;
    logic                rd_issue;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req     (req),
        .last    (last_gnt),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    always_comb begin
        // Owner keeps the port only while its lock is high; a dropped lock re-arbitrates this cycle.
        hold      = (state == ARB_OWNED) && lock[owner];
        sel_any   = hold ? req[owner] : rr_any;
        sel_idx   = hold ? owner : rr_idx;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        gnt_int   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_we     = we[i];
                sel_addr   = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata  = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                gnt_int[i] = sel_any;
            end
        end
        oor      = 32'(sel_addr) >= RAM_DEPTH;
        rd_issue = sel_any && !oor && !sel_we;
    end

    assign gnt       = rst_n ? gnt_int : '0;
    assign err       = (rst_n && oor) ? gnt_int : '0;
    assign ram_en    = rst_n && sel_any && !oor;
    assign ram_we    = ram_en && sel_we;
    assign ram_addr  = ram_en ? sel_addr : '0;
    assign ram_wdata = ram_en ? sel_wdata : '0;
    assign rdata     = (|rvalid) ? ram_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            last_gnt <= IDX_W'(NUM_REQ - 1);
            rvalid   <= '0;
        end else begin
            rvalid <= rd_issue ? gnt_int : '0;
            if (sel_any) begin
                last_gnt <= sel_idx;
                owner    <= sel_idx;
                state    <= lock[sel_idx] ? ARB_OWNED : ARB_IDLE;
            end else if (!hold) begin
                state <= ARB_IDLE;
            end
        end
    end

`ifdef RAM_PORT_ARBITER_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (|err) begin
            err_count <= err_cnt_inc(err_count);
        end
    end
`else
    // No error counter in this build.
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: model pushes expected per-cycle outputs, monitor compares.
module tb_ram_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int DEPTH = 200;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req, lock, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]  gnt, rvalid, err;
    logic [DW-1:0] rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
`ifdef RAM_PORT_ARBITER_ERR_CNT_EN
    logic [15:0]   err_count;
`endif

    ram_port_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RAM_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .err       (err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
`ifdef RAM_PORT_ARBITER_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // Environment RAM: single port, one-cycle registered read.
    logic [7:0] ram_mem [256];
    bit         ram_inited = 1'b0;
    always @(posedge clk) begin
        if (!ram_inited) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= pat(i);
            ram_inited <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    typedef struct {
        bit          in_reset;
        logic [3:0]  gnt, err, rvalid;
        logic [7:0]  rdata;
        logic        ram_en, ram_we;
        logic [7:0]  ram_addr, ram_wdata;
        logic [15:0] errc;
    } exp_t;

    exp_t sb[$];
    int compared = 0;
    int mismatched = 0;

    // Reference model state
    logic [7:0] ref_mem [256];
    int  m_last = N - 1;
    bit  m_owned = 1'b0;
    int  m_owner = 0;
    bit  pend_v = 1'b0;
    int  pend_i = 0;
    logic [7:0] pend_d = '0;
    int  m_errc = 0;

    task automatic step(input bit rst, input logic [3:0] rq, input logic [3:0] lk,
                        input logic [3:0] w, input logic [31:0] ad, input logic [31:0] wd);
        exp_t e;
        int g;
        int a;
        bit free;
        @(posedge clk);
        #1;
        rst_n = rst; req = rq; lock = lk; we = w; addr = ad; wdata = wd;
        e = '{default: '0};
        if (!rst) begin
            e.in_reset = 1'b1;
            m_last = N - 1; m_owned = 1'b0; m_owner = 0; pend_v = 1'b0; m_errc = 0;
        end else begin
            if (pend_v) begin
                e.rvalid[pend_i] = 1'b1;
                e.rdata = pend_d;
            end
            pend_v = 1'b0;
            free = !m_owned || !lk[m_owner];
            g = -1;
            if (free) begin
                for (int k = 1; k <= N; k++)
                    if (g < 0 && rq[(m_last + k) % N]) g = (m_last + k) % N;
            end else if (rq[m_owner]) begin
                g = m_owner;
            end
            if (g >= 0) begin
                a = int'(ad[g*8 +: 8]);
                e.gnt[g] = 1'b1;
                if (a >= DEPTH) begin
                    e.err[g] = 1'b1;
                end else begin
                    e.ram_en = 1'b1;
                    e.ram_we = w[g];
                    e.ram_addr = 8'(a);
                    if (w[g]) begin
                        e.ram_wdata = wd[g*8 +: 8];
                        ref_mem[a] = wd[g*8 +: 8];
                    end else begin
                        pend_v = 1'b1; pend_i = g; pend_d = ref_mem[a];
                    end
                end
                m_last = g; m_owned = lk[g]; m_owner = g;
            end else if (free) begin
                m_owned = 1'b0;
            end
            e.errc = 16'(m_errc);
            if (e.err != 0 && m_errc < 16'hFFFF) m_errc++;
        end
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("err", 32'(err), 32'(e.err));
                chk("rvalid", 32'(rvalid), 32'(e.rvalid));
                chk("ram_en", 32'(ram_en), 32'(e.ram_en));
                if (e.ram_en || e.in_reset) begin
                    chk("ram_we", 32'(ram_we), 32'(e.ram_we));
                    chk("ram_addr", 32'(ram_addr), 32'(e.ram_addr));
                end
                if (e.ram_we || e.in_reset) chk("ram_wdata", 32'(ram_wdata), 32'(e.ram_wdata));
                if (e.rvalid != 0 || e.in_reset) chk("rdata", 32'(rdata), 32'(e.rdata));
`ifdef RAM_PORT_ARBITER_ERR_CNT_EN
                chk("err_count", 32'(err_count), 32'(e.errc));
`endif
            end
        end
    end

    initial begin : stim
        logic [31:0] ad, wd;
        logic [3:0]  lk;
        rst_n = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);

        step(1'b0, 4'b1111, 4'b0000, 4'b0000, 32'h0, 32'h0);
        step(1'b0, 4'b1111, 4'b0000, 4'b0000, 32'h0, 32'h0);

        // Round-robin rotation with all four reading.
        for (int c = 0; c < 5; c++)
            step(1'b1, 4'b1111, 4'b0000, 4'b0000, 32'h0C_08_04_00 + 32'(c), 32'h0);
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);

        // Write from 2 then read back by 1.
        step(1'b1, 4'b0100, 4'b0000, 4'b0100, 32'h00_10_00_00, 32'h00_A5_00_00);
        step(1'b1, 4'b0010, 4'b0000, 4'b0000, 32'h00_00_10_00, 32'h0);
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);

        // Lock ownership: 0 first so 1 wins next, then 1 holds for three cycles.
        step(1'b1, 4'b0001, 4'b0000, 4'b0000, 32'h30_20_10_05, 32'h0);
        for (int c = 0; c < 3; c++)
            step(1'b1, 4'b1111, 4'b0010, 4'b0000, 32'h30_20_10_05, 32'h0);
        step(1'b1, 4'b1111, 4'b0000, 4'b0000, 32'h30_20_10_05, 32'h0);
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);

        // Out-of-range access and the last in-range word.
        step(1'b1, 4'b1000, 4'b0000, 4'b0000, 32'hC8_00_00_00, 32'h0);
        step(1'b1, 4'b1000, 4'b0000, 4'b0000, 32'hC7_00_00_00, 32'h0);
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);

        // Reset right after a read grant abandons the read.
        step(1'b1, 4'b0100, 4'b0000, 4'b0000, 32'h00_22_00_00, 32'h0);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);
        step(1'b1, 4'b1111, 4'b0000, 4'b0000, 32'h04_03_02_01, 32'h0);
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);

        for (int c = 0; c < 400; c++) begin
            ad = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
            wd = $urandom;
            lk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            step(($urandom_range(0, 99) != 0), 4'($urandom), lk, 4'($urandom), ad, wd);
        end
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0);

        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, RAM address width.
REQ-004 SHALL have parameter RAM_DEPTH, default 1 << ADDR_WIDTH, number of valid words.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  in  NUM_REQ  per-requester access request.
REQ-008 SHALL have port lock  in  NUM_REQ  per-requester hold-ownership request.
REQ-009 SHALL have port we  in  NUM_REQ  per-requester write enable.
REQ-010 SHALL have port addr  in  NUM_REQ*ADDR_WIDTH  per-requester address, packed.
REQ-011 SHALL have port wdata  in  NUM_REQ*DATA_WIDTH  per-requester write data, packed.
REQ-012 SHALL have port gnt  out  NUM_REQ  one-hot access accepted this cycle.
REQ-013 SHALL have port rvalid  out  NUM_REQ  one-hot read data valid.
REQ-014 SHALL have port rdata  out  DATA_WIDTH  read data, shared by all requesters.
REQ-015 SHALL have port err  out  NUM_REQ  one-cycle pulse, out-of-range access rejected.
REQ-016 SHALL have ports ram_en/ram_we  out  1 each, ram_addr  out  ADDR_WIDTH, ram_wdata  out  DATA_WIDTH, ram_rdata  in  DATA_WIDTH; single-port RAM, 1-cycle read latency.

Function
REQ-017 SHALL be a two-state FSM: IDLE (round-robin arbitration) and OWNED (locked requester only).
REQ-018 SHALL, in IDLE, grant the first requesting index after last_gnt, wrapping NUM_REQ-1 -> 0; last_gnt resets to NUM_REQ-1 so index 0 wins first.
REQ-019 SHALL assert gnt combinationally in the cycle the access drives the RAM; at most one gnt bit high.
REQ-020 SHALL drive ram_en=1, ram_we, ram_addr, ram_wdata from the granted requester in the grant cycle; ram_en=0 otherwise.
REQ-021 SHALL, for a granted read, assert rvalid[i] with rdata=ram_rdata exactly one cycle after gnt[i].
REQ-022 SHALL sustain one access per cycle (back-to-back grants, including same requester).
REQ-023 SHALL transition IDLE->OWNED when a granted requester has lock high; OWNED grants only that requester.
REQ-024 SHALL transition OWNED->IDLE on the first cycle owner's lock is low (that cycle is arbitrated round-robin); owner req low with lock high leaves the port idle.
REQ-025 SHALL treat addr >= RAM_DEPTH as out-of-range: gnt and err pulse together, ram_en=0, no rvalid.
REQ-026 SHALL ignore lock from non-granted requesters and lock without req.

Reset
REQ-027 SHALL, while rst_n low, force state=IDLE, gnt=0, rvalid=0, err=0, rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-028 SHALL abandon an in-flight read on reset assertion (no rvalid after rst_n release).

Configuration
REQ-029 SHALL, with RAM_PORT_ARBITER_ERR_CNT_EN defined, add output err_count (16 bits), incremented per err pulse, saturating at 16'hFFFF, reset 0.
REQ-030 SHALL, without RAM_PORT_ARBITER_ERR_CNT_EN, omit err_count port and counter logic; all other behaviour unchanged.

Structure
REQ-031 SHALL place the FSM state enum (ARB_IDLE, ARB_OWNED) and error-counter width constant in package ram_port_arbiter_pkg.
REQ-032 SHALL instantiate sub-module rr_picker (request vector + last-grant index -> one-hot grant) for round-robin selection.

Verification
REQ-033 SHALL cover: req=4'b1111 held, all reads -> gnt 0,1,2,3,0 on consecutive cycles, each rvalid one cycle later.
REQ-034 SHALL cover: req[2] write addr=8'h10 wdata=8'hA5, then req[1] read addr=8'h10 -> rvalid[1] with rdata=8'hA5.
REQ-035 SHALL cover: req[1]+lock[1] for 3 cycles with req=4'b1111 -> gnt[1] three cycles, then gnt[2] when lock drops.
REQ-036 SHALL cover: RAM_DEPTH=200, req[3] addr=8'd200 -> gnt[3] and err[3] pulse, ram_en=0, no rvalid; err_count=1 when macro defined.
REQ-037 SHALL cover: rst_n low the cycle after a read grant -> no rvalid after release, next grant goes to index 0.
